// File: rtl/rom_loader_pkg.sv
// Shared types and the lane placement helper for the ioctl-to-ddram quadword packer.
package rom_loader_pkg;

   localparam int QW_BYTES = 8;

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, FACK} state_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  be;
   } lane_t;

   // Byte-swapped word moved into its 16-bit lane, with the matching byte enables.
   function automatic lane_t lane_swap(input logic [15:0] word, input logic [1:0] lane);
      lane_t r;
      r.data = {48'd0, word[7:0], word[15:8]} << {lane, 4'b0000};
      r.be   = 8'b0000_0011 << {lane, 1'b0};
      return r;
   endfunction

endpackage

// File: rtl/rom_loader_pack.sv
// Packs the 16-bit ioctl download stream into byte-swapped 64-bit ddram writes,
// with ioctl_wait back-pressure, end-of-download flush, ROM size and done pulse.
module rom_loader_pack
   import rom_loader_pkg::*;
#(
   parameter int ADDR_W = 25
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              dl_active,
   input  logic              dl_wr,
   input  logic [ADDR_W-1:0] dl_addr,
   input  logic [15:0]       dl_data,
   output logic              dl_wait,
   output logic [ADDR_W-4:0] wr_addr,
   output logic [63:0]       wr_data,
   output logic [7:0]        wr_be,
   output logic              wr_req,
   input  logic              wr_ack,
   output logic [ADDR_W-1:0] rom_size,
   output logic              done
);

   localparam int QA_W = ADDR_W - $clog2(QW_BYTES);

   state_t            state, state_nx;
   logic              act_q, rise, fall, capture, slot_free;
   logic              iw_valid;
   logic [ADDR_W-1:1] iw_addr;
   logic [15:0]       iw_data;
   logic [QA_W-1:0]   iw_qaddr;
   lane_t             iw_lane;
   logic [63:0]       lane_mask;
   logic              asm_valid;
   logic [63:0]       asm_data;
   logic [7:0]        asm_be;
   logic [QA_W-1:0]   asm_qaddr;
   logic              do_merge, do_push, push_load, done_nx;
   logic [ADDR_W-1:0] size_cand;

   assign rise      = dl_active & ~act_q;
   assign fall      = ~dl_active & act_q;
   assign capture   = dl_wr & dl_active;
   assign slot_free = (wr_req == wr_ack);
   assign iw_qaddr  = iw_addr[ADDR_W-1:3];
   assign iw_lane   = lane_swap(iw_data, iw_addr[2:1]);
   // Setting bit 0 then adding 1 equals clearing bit 0 then adding 2.
   assign size_cand = (dl_addr | ADDR_W'(1)) + ADDR_W'(1);
   assign dl_wait   = iw_valid;

   always_comb begin
      lane_mask = '0;
      for (int k = 0; k < QW_BYTES; k++) begin
         lane_mask[8*k +: 8] = {8{iw_lane.be[k]}};
      end
   end

   always_comb begin
      state_nx  = state;
      do_merge  = 1'b0;
      do_push   = 1'b0;
      push_load = 1'b0;
      done_nx   = 1'b0;
      if (iw_valid) begin
         if (!asm_valid || asm_qaddr == iw_qaddr) begin
            do_merge = 1'b1;
         end else if (slot_free) begin
            do_push   = 1'b1;
            push_load = 1'b1;
         end
      end else if (asm_valid && slot_free && (asm_be == 8'hFF || state == FLUSH)) begin
         do_push = 1'b1;
      end
      case (state)
         IDLE:    state_nx = IDLE;
         LOAD:    if (fall) state_nx = FLUSH;
         FLUSH:   if (!iw_valid && !asm_valid) state_nx = FACK;
         FACK: begin
            if (slot_free) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
      // A new download abandons whatever is still assembling; an in-flight write is left alone.
      if (rise) begin
         state_nx  = LOAD;
         do_merge  = 1'b0;
         do_push   = 1'b0;
         push_load = 1'b0;
         done_nx   = 1'b0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state     <= IDLE;
         act_q     <= 1'b0;
         iw_valid  <= 1'b0;
         iw_addr   <= '0;
         iw_data   <= '0;
         asm_valid <= 1'b0;
         asm_data  <= '0;
         asm_be    <= '0;
         asm_qaddr <= '0;
         wr_req    <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         wr_be     <= '0;
         rom_size  <= '0;
         done      <= 1'b0;
      end else begin
         act_q <= dl_active;
         state <= state_nx;
         done  <= done_nx;
         if (do_merge) begin
            asm_valid <= 1'b1;
            asm_qaddr <= iw_qaddr;
            asm_data  <= ((asm_valid ? asm_data : 64'd0) & ~lane_mask) | iw_lane.data;
            asm_be    <= (asm_valid ? asm_be : 8'd0) | iw_lane.be;
         end
         if (do_push) begin
            wr_req  <= ~wr_req;
            wr_addr <= asm_qaddr;
            wr_data <= asm_data;
            wr_be   <= asm_be;
            if (push_load) begin
               asm_qaddr <= iw_qaddr;
               asm_data  <= iw_lane.data;
               asm_be    <= iw_lane.be;
            end else begin
               asm_valid <= 1'b0;
            end
         end
         if (do_merge || push_load) iw_valid <= 1'b0;
         if (rise) begin
            asm_valid <= 1'b0;
            iw_valid  <= 1'b0;
            rom_size  <= '0;
         end
         // A strobe landing on the rising-edge cycle belongs to the new download.
         if (capture) begin
            iw_valid <= 1'b1;
            iw_addr  <= dl_addr[ADDR_W-1:1];
            iw_data  <= dl_data;
            if (rise || size_cand > rom_size) rom_size <= size_cand;
         end
      end
   end

endmodule

// File: tb/tb_rom_loader_pack.sv
// Randomized bench for rom_loader_pack: host driver, toggle-handshake ddram responder,
// run-grouping reference model and a write scoreboard.
module tb_rom_loader_pack;

   localparam int ADDR_W = 25;
   localparam int QA_W   = ADDR_W - 3;
   localparam int EW     = QA_W + 8 + 64;

   logic              clk_sys = 1'b0;
   logic              reset_n = 1'b0;
   logic              dl_active = 1'b0;
   logic              dl_wr = 1'b0;
   logic [ADDR_W-1:0] dl_addr = '0;
   logic [15:0]       dl_data = '0;
   logic              wr_ack = 1'b0;
   logic              dl_wait;
   logic [QA_W-1:0]   wr_addr;
   logic [63:0]       wr_data;
   logic [7:0]        wr_be;
   logic              wr_req;
   logic [ADDR_W-1:0] rom_size;
   logic              done;

   rom_loader_pack #(.ADDR_W(ADDR_W)) dut (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .dl_active(dl_active),
      .dl_wr    (dl_wr),
      .dl_addr  (dl_addr),
      .dl_data  (dl_data),
      .dl_wait  (dl_wait),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_be    (wr_be),
      .wr_req   (wr_req),
      .wr_ack   (wr_ack),
      .rom_size (rom_size),
      .done     (done)
   );

   always #5 clk_sys = ~clk_sys;

   int                vectors = 0;
   int                miscompares = 0;
   logic [EW-1:0]     exp_q[$];
   logic [ADDR_W-1:0] w_addr[$];
   logic [15:0]       w_data[$];
   logic [EW-1:0]     last_wr = '0;
   int                wr_cnt = 0;
   int                done_cnt = 0;
   int                ack_delay = 2;
   bit                ack_hold = 1'b0;
   bit                pending = 1'b0;
   logic              prev_req = 1'b0;
   int                ack_cnt = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   function automatic logic [63:0] be_mask(input logic [7:0] be);
      logic [63:0] m;
      for (int k = 0; k < 8; k++) m[8*k +: 8] = {8{be[k]}};
      return m;
   endfunction

   // ddram side: echoes the request toggle after ack_delay cycles unless held.
   initial begin
      forever begin
         @(posedge clk_sys);
         #2;
         if (!reset_n) begin
            wr_ack  = 1'b0;
            ack_cnt = 0;
         end else if (!ack_hold && wr_req != wr_ack) begin
            if (ack_cnt >= ack_delay) begin
               wr_ack  = wr_req;
               ack_cnt = 0;
            end else begin
               ack_cnt++;
            end
         end
      end
   end

   // Scoreboard: every request toggle is one write, compared on its enabled bytes.
   initial begin
      logic [EW-1:0] cur;
      forever begin
         @(negedge clk_sys);
         if (!reset_n) begin
            prev_req = 1'b0;
            pending  = 1'b0;
         end else begin
            if (done) begin
               done_cnt++;
               check("done_after_ack", 128'(wr_ack), 128'(wr_req));
            end
            if (pending && wr_ack == wr_req) begin
               check("wr_stable", 128'({wr_addr, wr_be, wr_data & be_mask(wr_be)}), 128'(last_wr));
               pending = 1'b0;
            end
            if (wr_req != prev_req) begin
               check("wr_overlap", 128'(pending), 128'(0));
               prev_req = wr_req;
               wr_cnt++;
               cur      = {wr_addr, wr_be, wr_data & be_mask(wr_be)};
               last_wr  = cur;
               pending  = 1'b1;
               if (exp_q.size() == 0) check("wr_unexpected", 128'(cur), 128'(0));
               else check("wr_content", 128'(cur), 128'(exp_q.pop_front()));
            end
         end
      end
   end

   // Reference: consecutive words sharing a quadword form one write; a write closes
   // when the quadword changes, when all eight bytes are present, or at the end.
   task automatic build_expect(output int exp_size);
      logic [63:0]     d;
      logic [7:0]      be;
      logic [QA_W-1:0] qa, cur;
      bit              open;
      int              lane, top;
      open = 1'b0; d = '0; be = '0; cur = '0; exp_size = 0;
      foreach (w_addr[i]) begin
         qa   = QA_W'(w_addr[i] / 8);
         lane = int'(w_addr[i] % 8) / 2;
         if (open && qa != cur) begin
            exp_q.push_back({cur, be, d});
            open = 1'b0;
         end
         if (!open) begin
            open = 1'b1; cur = qa; d = '0; be = '0;
         end
         d[16*lane +: 16] = {w_data[i][7:0], w_data[i][15:8]};
         be[2*lane +: 2]  = 2'b11;
         if (be == 8'hFF) begin
            exp_q.push_back({cur, be, d});
            open = 1'b0;
         end
         top = (int'(w_addr[i]) / 2) * 2 + 2;
         if (top > exp_size) exp_size = top;
      end
      if (open) exp_q.push_back({cur, be, d});
   endtask

   task automatic add_word(input logic [ADDR_W-1:0] a, input logic [15:0] d);
      w_addr.push_back(a);
      w_data.push_back(d);
   endtask

   task automatic send_word(input logic [ADDR_W-1:0] a, input logic [15:0] d);
      int budget;
      dl_addr = a;
      dl_data = d;
      dl_wr   = 1'b1;
      tick();
      dl_wr = 1'b0;
      check("dl_wait_set", 128'(dl_wait), 128'(1));
      budget = 200;
      while (dl_wait && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0) check("dl_wait_timeout", 128'(dl_wait), 128'(0));
   endtask

   task automatic run_download(input string name);
      int exp_size, d0, budget;
      build_expect(exp_size);
      d0 = done_cnt;
      dl_active = 1'b1;
      tick();
      tick();
      foreach (w_addr[i]) send_word(w_addr[i], w_data[i]);
      dl_active = 1'b0;
      budget = 500;
      while (done_cnt == d0 && budget > 0) begin
         tick();
         budget--;
      end
      repeat (3) tick();
      check({name, "_done"}, 128'(done_cnt - d0), 128'(1));
      check({name, "_size"}, 128'(rom_size), 128'(exp_size));
      check({name, "_drain"}, 128'(exp_q.size()), 128'(0));
      w_addr.delete();
      w_data.delete();
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_wait"}, 128'(dl_wait), 128'(0));
      check({name, "_req"},  128'(wr_req),  128'(0));
      check({name, "_addr"}, 128'(wr_addr), 128'(0));
      check({name, "_data"}, 128'(wr_data), 128'(0));
      check({name, "_be"},   128'(wr_be),   128'(0));
      check({name, "_size"}, 128'(rom_size), 128'(0));
      check({name, "_done"}, 128'(done),    128'(0));
   endtask

   initial begin
      int                w0, d0, budget, n, mode, sz;
      logic [ADDR_W-1:0] a, base;
      logic [QA_W-1:0]   cur_qa;
      logic [7:0]        run_be;
      bit                have;

      reset_n = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      reset_n = 1'b1;
      tick();

      // Four sequential words make one full quadword.
      add_word(0, 16'h1234); add_word(2, 16'h5678); add_word(4, 16'h9ABC); add_word(6, 16'hDEF0);
      w0 = wr_cnt;
      run_download("seq4");
      check("seq4_writes", 128'(wr_cnt - w0), 128'(1));
      check("seq4_addr", 128'(wr_addr), 128'(0));
      check("seq4_be", 128'(wr_be), 128'(8'hFF));
      check("seq4_lo", 128'(wr_data[15:0]), 128'(16'h3412));

      // Partial quadword flushed at the end of the download.
      add_word(0, 16'h1111); add_word(2, 16'h2222); add_word(4, 16'h3333);
      run_download("part3");
      check("part3_be", 128'(wr_be), 128'(8'h3F));

      // Acknowledge withheld while a 24-byte stream keeps coming.
      for (int i = 0; i < 12; i++) add_word(ADDR_W'(2 * i), 16'($urandom));
      ack_hold = 1'b1;
      w0 = wr_cnt;
      fork
         run_download("hold");
         begin
            repeat (34) tick();
            check("hold_wait", 128'(dl_wait), 128'(1));
            check("hold_writes", 128'(wr_cnt - w0), 128'(1));
            ack_hold = 1'b0;
         end
      join
      check("hold_total", 128'(wr_cnt - w0), 128'(3));

      // Non-sequential quadwords each get their own write.
      add_word(ADDR_W'(16), 16'hAB01); add_word(ADDR_W'(8), 16'hCD02);
      w0 = wr_cnt;
      run_download("nonseq");
      check("nonseq_writes", 128'(wr_cnt - w0), 128'(2));
      check("nonseq_addr", 128'(wr_addr), 128'(1));
      check("nonseq_be", 128'(wr_be), 128'(8'h03));

      // Reset in the middle of a download.
      d0 = done_cnt;
      dl_active = 1'b1;
      tick();
      tick();
      send_word(0, 16'h4321);
      send_word(2, 16'h8765);
      check("mid_size", 128'(rom_size), 128'(4));
      reset_n   = 1'b0;
      dl_active = 1'b0;
      tick();
      check_reset_outputs("mid_reset");
      reset_n = 1'b1;
      repeat (10) tick();
      check("mid_no_done", 128'(done_cnt - d0), 128'(0));
      exp_q.delete();
      add_word(0, 16'h0BAD);
      run_download("post_rst");

      // New download starting while the final write still awaits its ack.
      ack_delay = 12;
      d0 = done_cnt;
      w0 = wr_cnt;
      add_word(0, 16'hA55A); add_word(2, 16'h0FF0);
      build_expect(sz);
      dl_active = 1'b1;
      tick();
      tick();
      foreach (w_addr[i]) send_word(w_addr[i], w_data[i]);
      w_addr.delete();
      w_data.delete();
      dl_active = 1'b0;
      budget = 50;
      while (wr_cnt == w0 && budget > 0) begin
         tick();
         budget--;
      end
      repeat (3) tick();
      check("fack_pending", 128'(wr_req ^ wr_ack), 128'(1));
      for (int i = 0; i < 4; i++) add_word(ADDR_W'(64 + 2 * i), 16'($urandom));
      run_download("fack_rise");
      check("fack_done_total", 128'(done_cnt - d0), 128'(1));

      // Random downloads: sequential runs or scattered/overwriting lanes.
      for (int r = 0; r < 12; r++) begin
         ack_delay = $urandom_range(0, 4);
         n    = $urandom_range(0, 16);
         mode = $urandom_range(0, 1);
         base = ADDR_W'($urandom_range(0, 31) * 2);
         have = 1'b0; cur_qa = '0; run_be = '0; a = '0;
         for (int i = 0; i < n; i++) begin
            if (mode == 0) begin
               a = base + ADDR_W'(2 * i);
            end else if (have && run_be != 8'hFF && $urandom_range(0, 1) == 1) begin
               a = (a & ~ADDR_W'(7)) | ADDR_W'($urandom_range(0, 3) * 2);
            end else begin
               a = ADDR_W'($urandom_range(0, 127) * 2);
               if (have && run_be == 8'hFF && a[ADDR_W-1:3] == cur_qa) a = a + ADDR_W'(8);
            end
            if (!have || a[ADDR_W-1:3] != cur_qa) begin
               cur_qa = a[ADDR_W-1:3];
               run_be = '0;
               have   = 1'b1;
            end
            run_be[2 * int'(a[2:1]) +: 2] = 2'b11;
            add_word(a, 16'($urandom));
         end
         run_download("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
